pedestrian_monitor: RTL

- Independent safety monitor at the receiving end of the pedestrian controller's lamp interface.
- Samples the five lamp drives (car green/yellow/red, pedestrian green/red) and reconstructs the controller's phase.
- Checks lamp patterns, phase order and per-phase dwell times; latches the first violation as a sticky fault with a code and drives a fault LED.
- Sits beside the controller on the same 16 MHz clock; instantiated in the board top level and in the controller benches.

---
 rtl/ped_pkg.sv | 36 +++
 rtl/ped_dwell_timer.sv | 43 ++++
 rtl/pedestrian_monitor.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian lamp interface: phase encoding,
// monitor fault codes and the four legal lamp patterns {green,yellow,red,ped_green,ped_red}.
package ped_pkg;

    typedef enum logic [2:0] {
        PH_SYNC    = 3'd0,
        PH_GREEN   = 3'd1,
        PH_YELLOW  = 3'd2,
        PH_CLEAR_A = 3'd3,
        PH_WALK    = 3'd4,
        PH_CLEAR_B = 3'd5
    } phase_t;

    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_ILLEGAL = 3'd1;
    localparam logic [2:0] FC_SEQ     = 3'd2;
    localparam logic [2:0] FC_SHORT   = 3'd3;
    localparam logic [2:0] FC_TIMEOUT = 3'd4;

    localparam logic [4:0] P_GREEN  = 5'b10001;
    localparam logic [4:0] P_YELLOW = 5'b01001;
    localparam logic [4:0] P_ALLRED = 5'b00101;
    localparam logic [4:0] P_WALK   = 5'b00110;

    // All-red is ambiguous on its own; the phase it is entered from decides which clearance it is.
    function automatic phase_t phase_of_pattern(input logic [4:0] pat, input phase_t from);
        case (pat)
            P_GREEN:  return PH_GREEN;
            P_YELLOW: return PH_YELLOW;
            P_WALK:   return PH_WALK;
            P_ALLRED: return (from == PH_WALK) ? PH_CLEAR_B : PH_CLEAR_A;
            default:  return from;
        endcase
    endfunction

endpackage

// File: rtl/ped_dwell_timer.sv
// Prescaler plus saturating 8-bit dwell counter; the cycle with i_clr high counts as
// the first clock of the new phase, so a phase held N ticks reads N on its exit cycle.
module ped_dwell_timer #(
    parameter int TIMER_SCALE = 16000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    output logic [7:0] o_dwell
);

    localparam int PW = (TIMER_SCALE > 1) ? $clog2(TIMER_SCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_SCALE - 1);

    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_base;
    logic [7:0]    r_dwell;
    logic [7:0]    w_dwell_base;
    logic          w_tick;

    always_comb begin
        w_presc_base = i_clr ? '0 : r_presc;
        w_dwell_base = i_clr ? 8'd0 : r_dwell;
        w_tick       = (w_presc_base == PRESC_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_dwell <= 8'd0;
        end else begin
            r_presc <= w_tick ? '0 : w_presc_base + 1'b1;
            if (w_tick && (w_dwell_base != 8'hFF)) begin
                r_dwell <= w_dwell_base + 8'd1;
            end else begin
                r_dwell <= w_dwell_base;
            end
        end
    end

    assign o_dwell = r_dwell;

endmodule

// File: rtl/pedestrian_monitor.sv
// Safety monitor: rebuilds the controller phase from the lamp drives and latches the first
// pattern/sequence/dwell violation; fault visible 2 clocks after the offending lamp change.
module pedestrian_monitor
    import ped_pkg::*;
#(
    parameter int TIMER_SCALE = 16000000,
    parameter int MIN_GREEN   = 5,
    parameter int MIN_YELLOW  = 2,
    parameter int MIN_CLEAR   = 1,
    parameter int MIN_WALK    = 4,
    parameter int MAX_PHASE   = 60
) (
    input  logic       pin3_clk_16mhz,
    input  logic       pin9_rst_n,
    input  logic       green,
    input  logic       yellow,
    input  logic       red,
    input  logic       ped_green,
    input  logic       ped_red,
    output logic [2:0] phase,
    output logic       synced,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       pin10_fault_led
);

    logic [4:0] r_lamp_q;
    logic [4:0] r_lamp_prev;
    logic       r_lamp_vld;
    phase_t     r_phase;
    phase_t     w_phase_nxt;
    logic       r_fault;
    logic [2:0] r_fault_code;
    logic [2:0] w_code;
    logic [7:0] w_dwell;
    logic [7:0] w_min_dwell;
    logic [4:0] w_exp_pat;
    logic       w_legal;
    logic       w_chg;
    logic       w_tracked;
    logic       w_step;

    ped_dwell_timer #(
        .TIMER_SCALE(TIMER_SCALE)
    ) u_dwell (
        .i_clk   (pin3_clk_16mhz),
        .i_rst_n (pin9_rst_n),
        .i_clr   (w_chg),
        .o_dwell (w_dwell)
    );

    always_comb begin
        w_legal   = (r_lamp_q == P_GREEN) || (r_lamp_q == P_YELLOW) ||
                    (r_lamp_q == P_ALLRED) || (r_lamp_q == P_WALK);
        w_chg     = (r_lamp_q != r_lamp_prev);
        w_tracked = (r_phase != PH_SYNC);
        w_step    = r_lamp_vld && w_legal && w_chg && w_tracked;

        w_exp_pat   = P_GREEN;
        w_min_dwell = 8'd0;
        unique case (r_phase)
            PH_GREEN:   begin w_exp_pat = P_YELLOW; w_min_dwell = 8'(MIN_GREEN);  end
            PH_YELLOW:  begin w_exp_pat = P_ALLRED; w_min_dwell = 8'(MIN_YELLOW); end
            PH_CLEAR_A: begin w_exp_pat = P_WALK;   w_min_dwell = 8'(MIN_CLEAR);  end
            PH_WALK:    begin w_exp_pat = P_ALLRED; w_min_dwell = 8'(MIN_WALK);   end
            PH_CLEAR_B: begin w_exp_pat = P_GREEN;  w_min_dwell = 8'(MIN_CLEAR);  end
            default:    begin w_exp_pat = P_GREEN;  w_min_dwell = 8'd0;           end
        endcase

        w_phase_nxt = r_phase;
        if (r_lamp_vld && w_legal) begin
            if (!w_tracked) begin
                if (r_lamp_q == P_GREEN) begin
                    w_phase_nxt = PH_GREEN;
                end
            end else if (w_chg) begin
                w_phase_nxt = phase_of_pattern(r_lamp_q, r_phase);
            end
        end

        w_code = FC_NONE;
        if (r_lamp_vld && !w_legal) begin
            w_code = FC_ILLEGAL;
        end else if (w_step && (r_lamp_q != w_exp_pat)) begin
            w_code = FC_SEQ;
        end else if (w_step && (w_dwell < w_min_dwell)) begin
            w_code = FC_SHORT;
        end else if (w_tracked && (w_dwell >= 8'(MAX_PHASE))) begin
            w_code = FC_TIMEOUT;
        end
    end

    // r_lamp_vld keeps the cleared (all-dark) input register from reading as illegal after reset.
    always_ff @(posedge pin3_clk_16mhz) begin
        if (!pin9_rst_n) begin
            r_lamp_q     <= 5'd0;
            r_lamp_prev  <= 5'd0;
            r_lamp_vld   <= 1'b0;
            r_phase      <= PH_SYNC;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
        end else begin
            r_lamp_q    <= {green, yellow, red, ped_green, ped_red};
            r_lamp_prev <= r_lamp_q;
            r_lamp_vld  <= 1'b1;
            r_phase     <= w_phase_nxt;
            if (!r_fault && (w_code != FC_NONE)) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_code;
            end
        end
    end

    assign phase           = r_phase;
    assign synced          = (r_phase != PH_SYNC);
    assign fault           = r_fault;
    assign fault_code      = r_fault_code;
    assign pin10_fault_led = r_fault;

endmodule
